// File: rtl/alu_result_tracer.sv
// alu_result_tracer: debug capture stage behind the single-cycle MIPS top level.
// Each enabled cycle the ALU result is stamped with a free-running cycle count
// and pushed into a show-ahead FIFO that drains over a valid/ready handshake.
// When the FIFO is full, samples are dropped rather than stalling the processor.
// A sticky flag and a saturating counter record the drops.
//
// Optional feature, macro TRACE_DEDUP_EN: when defined, a sample is pushed only
// if it differs from the last accepted value. The first enabled cycle after
// reset, and the first after CaptureEnable rises, always push.
module alu_result_tracer #(
    parameter int DEPTH       = 16,
    parameter int STAMP_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     CaptureEnable,
    input  logic [31:0]              ALUResult,
    output logic [31:0]              TraceData,
    output logic [STAMP_WIDTH-1:0]   TraceStamp,
    output logic                     TraceValid,
    input  logic                     TraceReady,
    output logic [$clog2(DEPTH):0]   Level,
    output logic                     Overflow,
    output logic [7:0]               DropCount,
    input  logic                     ClearOverflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [PW-1:0]          PTR_ONE   = PW'(1);
    localparam logic [LW-1:0]          LVL_ONE   = LW'(1);
    localparam logic [LW-1:0]          LVL_FULL  = LW'(DEPTH);
    localparam logic [STAMP_WIDTH-1:0] STAMP_ONE = STAMP_WIDTH'(1);

    typedef struct packed {
        logic [STAMP_WIDTH-1:0] stamp;
        logic [31:0]            data;
    } entry_t;

    entry_t                 mem_q [DEPTH];

    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          count_q,  count_d;
    logic [STAMP_WIDTH-1:0] cycle_q,  cycle_d;
    logic                   ovf_q,    ovf_d;
    logic [7:0]             drops_q,  drops_d;

    logic                   valid;
    logic                   full;
    logic                   pop;
    logic                   push_cand;
    logic                   do_push;
    logic                   drop;
    entry_t                 head;

`ifdef TRACE_DEDUP_EN
    logic [31:0]            last_q,      last_d;
    logic                   have_last_q, have_last_d;
    logic                   en_prev_q;
`endif

    // Push/pop decisions and next-state for pointers, level, counter and drop tracking
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        drops_d  = drops_q;
        cycle_d  = cycle_q + STAMP_ONE;

        valid = (count_q != '0);
        full  = (count_q == LVL_FULL);
        pop   = valid & TraceReady;

`ifdef TRACE_DEDUP_EN
        last_d      = last_q;
        have_last_d = have_last_q;
        push_cand   = CaptureEnable &
                      (~have_last_q | ~en_prev_q | (ALUResult != last_q));
`else
        push_cand   = CaptureEnable;
`endif

        do_push = push_cand & (~full | pop);
        drop    = push_cand & full & ~pop;

        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;

        case ({do_push, pop})
            2'b10:   count_d = count_q + LVL_ONE;
            2'b01:   count_d = count_q - LVL_ONE;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear wins over the clear.
        if (ClearOverflow) begin
            ovf_d   = drop;
            drops_d = drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drops_q != 8'hFF) drops_d = drops_q + 8'd1;
        end

`ifdef TRACE_DEDUP_EN
        if (do_push) begin
            last_d      = ALUResult;
            have_last_d = 1'b1;
        end
`endif
    end

    // Control state: pointers, level, cycle counter and overflow tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cycle_q  <= '0;
            ovf_q    <= 1'b0;
            drops_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cycle_q  <= cycle_d;
            ovf_q    <= ovf_d;
            drops_q  <= drops_d;
        end
    end

`ifdef TRACE_DEDUP_EN
    // Last accepted value and CaptureEnable history for duplicate suppression
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q      <= '0;
            have_last_q <= 1'b0;
            en_prev_q   <= 1'b0;
        end else begin
            last_q      <= last_d;
            have_last_q <= have_last_d;
            en_prev_q   <= CaptureEnable;
        end
    end
`endif

    // Sample storage write port
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the empty level masks stale entries, which keeps it RAM-mappable.
        if (do_push) mem_q[wr_ptr_q] <= '{stamp: cycle_q, data: ALUResult};
    end

    // Show-ahead head presentation; zeroed while empty so the reset view is clean
    always_comb begin
        head       = mem_q[rd_ptr_q];
        TraceValid = valid;
        TraceData  = valid ? head.data  : '0;
        TraceStamp = valid ? head.stamp : '0;
        Level      = count_q;
        Overflow   = ovf_q;
        DropCount  = drops_q;
    end

endmodule

// File: doc/alu_result_tracer.md
# alu_result_tracer

Debug capture stage directly downstream of the single-cycle MIPS processor top level. It samples the processor's 32-bit ALU result output every enabled clock and stamps each sample with a free-running cycle count. Samples are buffered in a show-ahead FIFO and drained through a valid/ready handshake to a host-side consumer such as a UART bridge or a bench scoreboard. Overflow is reported with a sticky flag and a saturating drop counter, so the processor never stalls.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- STAMP_WIDTH, 16: width of the cycle stamp.

Ports:
- clk  in  1  processor clock; same clock as the processor top level.
- reset  in  1  asynchronous, active-low reset.
- CaptureEnable  in  1  when 1, the current ALUResult is a push candidate this cycle.
- ALUResult  in  32  processor ALU result output.
- TraceData  out  32  ALU result at the FIFO head.
- TraceStamp  out  STAMP_WIDTH  cycle stamp at the FIFO head.
- TraceValid  out  1  FIFO not empty.
- TraceReady  in  1  consumer accepts the head entry.
- Level  out  $clog2(DEPTH)+1  number of stored entries, 0 to DEPTH.
- Overflow  out  1  sticky; set when a push candidate was dropped.
- DropCount  out  8  dropped samples, saturating at 255.
- ClearOverflow  in  1  synchronous clear of Overflow and DropCount.

## Operation
- **Cycle counter:** STAMP_WIDTH bits. Reset value is 0. Increments every clock regardless of CaptureEnable and wraps to 0 after all-ones.
- **Push candidate:** a cycle with CaptureEnable=1, subject to the filter in Configuration. The stored entry is {counter value in that cycle, ALUResult}.
- **Pop:** occurs in a cycle where TraceValid=1 and TraceReady=1. TraceReady is ignored when the FIFO is empty.
- **Storage:** circular buffer with write pointer, read pointer, and count. Pointers wrap modulo DEPTH.
- **Full FIFO:**
  - Push candidate without a pop: the sample is dropped. Overflow is set to 1 and DropCount increments, holding at 255.
  - Push candidate with a pop in the same cycle: both complete, Level is unchanged and no drop occurs.
- **Empty FIFO:** a pop cannot occur. A push candidate is written normally.
- **Simultaneous push and pop when not full:** Level is unchanged. FIFO order is preserved.
- **ClearOverflow:** clears Overflow to 0 and DropCount to 0 on the next edge. If a drop occurs in the same cycle, the result is Overflow=1 and DropCount=1.
- **Reset** (asynchronous, at any time including mid-drain):
  - Pointers, Level, the counter, Overflow and DropCount go to 0 immediately.
  - Buffered entries are discarded. TraceValid goes to 0.
- **Reset values of outputs:** TraceValid=0, Level=0, Overflow=0, DropCount=0. TraceData=0 and TraceStamp=0; both are don't-care whenever TraceValid=0.

## Timing
- All state updates on the rising edge of clk; reset acts asynchronously, independent of clk.
- **Push-to-visible latency:** 1 cycle. A sample pushed at edge N appears on TraceData/TraceStamp with TraceValid=1 after edge N when the FIFO was empty.
- **Head output:** show-ahead. The head entry is presented combinationally from storage and stays stable while TraceValid=1 and TraceReady=0.
- **After a pop at edge N:** the next entry is presented after edge N, or TraceValid=0 if the FIFO is now empty.
- **Level, Overflow, DropCount:** registered; they reflect the state after the most recent edge.
- **Throughput:** one push and one pop per cycle sustained.

## Configuration
- Macro: TRACE_DEDUP_EN.
- **Defined:**
  - A push candidate additionally requires that ALUResult differs from the last pushed value.
  - The first enabled cycle after reset, and the first enabled cycle after CaptureEnable rises, always push.
  - The last-pushed register updates only on an accepted push, not on a drop.
  - Filtered cycles neither push nor count as drops.
- **Undefined:** every CaptureEnable=1 cycle is a push candidate, and the last-pushed logic is absent.

## Test plan
- **Reset then idle:** hold reset=0 for 3 cycles, then release with CaptureEnable=0 for 10 cycles. Required: TraceValid=0, Level=0, Overflow=0 throughout.
- **Single capture:** CaptureEnable=1 for one cycle with ALUResult=32'h0000_0007 at counter 5. Required: next cycle TraceValid=1, TraceData=7, TraceStamp=5. A TraceReady pulse then returns TraceValid to 0.
- **Fill and overflow:** DEPTH=16, TraceReady=0, CaptureEnable=1 for 20 cycles with values 1..20. Required: Level=16, entries 1..16 retained, Overflow=1, DropCount=4. A following ClearOverflow pulse gives Overflow=0, DropCount=0.
- **Full with concurrent pop:** FIFO full and TraceReady=1 with CaptureEnable=1 for 5 cycles. Required: Level stays 16, no drops, output order continues 1,2,3,...
- **Mid-drain reset:** 8 entries buffered and draining; assert reset asynchronously between edges. Required: TraceValid and Level drop to 0 immediately; after release the counter restarts at 0.
- **TRACE_DEDUP_EN defined:** inputs 3,3,3,9,9,3 with CaptureEnable=1. Required: FIFO holds 3,9,3 only; Level=3, DropCount=0.
